// File: rtl/note_scroll_controller_pkg.sv
// Shared types for the note scroll sequencer: FSM states, chord layout and row geometry.
package note_scroll_controller_pkg;

  localparam int unsigned NOTE_W   = 5;
  localparam int unsigned ROWS_DEF = 8;
  localparam int unsigned ROW_W    = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT_TICK,
    ST_SHIFT,
    ST_DRAW,
    ST_DONE
  } state_e;

  // One bit per lane, bit0 green .. bit4 orange
  typedef struct packed {
    logic orange;
    logic blue;
    logic yellow;
    logic red;
    logic green;
  } chord_t;

endpackage

// File: rtl/note_scroll_controller_tempo_tick_gen.sv
// Free-running tempo counter; tick marks the last cycle of each row period.
module tempo_tick_gen #(
  parameter int unsigned TICKS_PER_ROW = 12500000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(TICKS_PER_ROW);

  logic [CNT_W-1:0] count_q, count_d;

  assign tick = run && (count_q == CNT_W'(TICKS_PER_ROW - 1));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (tick) begin
      count_d = '0;
    end else if (run) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/note_scroll_controller.sv
// Sequences tempo-locked shifts of the note bank, chord fetch from the song ROM,
// and the per-shift row walk handed to the VGA row drawer.
module note_scroll_controller
  import note_scroll_controller_pkg::*;
#(
  parameter int unsigned TICKS_PER_ROW = 12500000,
  parameter int unsigned SONG_LEN      = 64,
  parameter int unsigned ADDR_W        = 6,
  parameter int unsigned ROWS          = ROWS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              pause,
  output logic [ADDR_W-1:0] song_addr,
  input  logic [NOTE_W-1:0] song_note,
  output logic              shift_enable,
  output logic [NOTE_W-1:0] fsm_notes,
  output logic [ROW_W-1:0]  y_level,
  output logic              row_valid,
  input  logic              row_ack,
  output logic              playing,
  output logic              done,
  output logic              overrun
);

  localparam int unsigned IDX_END = SONG_LEN + ROWS;
  localparam int unsigned IDX_W   = $clog2(IDX_END + 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic                pending_q, pending_d;
  logic                overrun_q, overrun_d;
  logic                fetched_q, fetched_d;
  chord_t              notes_q, notes_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                shift_q, shift_d;
  logic                valid_q, valid_d;
  logic [ROW_W-1:0]    y_q, y_d;
  logic                playing_q, playing_d;
  logic                done_q, done_d;

  logic tick_c, run_c, start_acc_c, xfer_c, last_row_c, in_song_c;

  assign start_acc_c = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign run_c       = (state_q != ST_IDLE) && (state_q != ST_DONE) && !pause;
  assign xfer_c      = valid_q && row_ack;
  assign last_row_c  = (row_q == ROW_W'(ROWS - 1));
  assign in_song_c   = (idx_q < IDX_W'(SONG_LEN));

  tempo_tick_gen #(
    .TICKS_PER_ROW(TICKS_PER_ROW)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clear(start_acc_c),
    .run  (run_c),
    .tick (tick_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (start_acc_c) state_d = ST_FETCH;
      ST_FETCH:         state_d = ST_WAIT_TICK;
      ST_WAIT_TICK:     if (pending_q || tick_c) state_d = ST_SHIFT;
      ST_SHIFT:         state_d = ST_DRAW;
      ST_DRAW: begin
        if (xfer_c && last_row_c) begin
          state_d = ((idx_q + IDX_W'(1)) < IDX_W'(IDX_END)) ? ST_FETCH : ST_DONE;
        end
      end
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    idx_d     = idx_q;
    row_d     = row_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    notes_d   = notes_q;
    addr_d    = addr_q;
    fetched_d = (state_q == ST_FETCH);

    // A tick is consumed directly in WAIT_TICK; elsewhere it queues, and a second one is lost
    if ((state_q == ST_WAIT_TICK) && (pending_q || tick_c)) begin
      pending_d = 1'b0;
    end else if (tick_c) begin
      if (pending_q) overrun_d = 1'b1;
      else           pending_d = 1'b1;
    end

    if (start_acc_c) begin
      idx_d     = '0;
      overrun_d = 1'b0;
      pending_d = 1'b0;
    end

    unique case (state_q)
      ST_WAIT_TICK: if (fetched_q) notes_d = in_song_c ? chord_t'(song_note) : '0;
      ST_SHIFT:     row_d = '0;
      ST_DRAW: begin
        if (xfer_c) begin
          if (last_row_c) idx_d = idx_q + IDX_W'(1);
          else            row_d = row_q + ROW_W'(1);
        end
      end
      default: ;
    endcase

    // Drain fetches keep the last real address on the ROM bus
    if ((state_d == ST_FETCH) && (idx_d < IDX_W'(SONG_LEN))) addr_d = ADDR_W'(idx_d);
    if (state_d == ST_DONE) notes_d = '0;

    shift_d   = (state_d == ST_SHIFT);
    valid_d   = (state_d == ST_DRAW);
    y_d       = (state_d == ST_DRAW) ? row_d : '0;
    playing_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q     <= '0;
      row_q     <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      fetched_q <= 1'b0;
      notes_q   <= '0;
      addr_q    <= '0;
      shift_q   <= 1'b0;
      valid_q   <= 1'b0;
      y_q       <= '0;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      row_q     <= row_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      fetched_q <= fetched_d;
      notes_q   <= notes_d;
      addr_q    <= addr_d;
      shift_q   <= shift_d;
      valid_q   <= valid_d;
      y_q       <= y_d;
      playing_q <= playing_d;
      done_q    <= done_d;
    end
  end

  assign song_addr    = addr_q;
  assign shift_enable = shift_q;
  assign fsm_notes    = notes_q;
  assign y_level      = y_q;
  assign row_valid    = valid_q;
  assign playing      = playing_q;
  assign done         = done_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_note_scroll_controller.sv
// Scoreboard bench: dut_a (4-cycle tempo) for full runs, dut_b (16-cycle tempo) for stalls, pause and reset.
module tb_note_scroll_controller;

  typedef struct {
    int cyc;
    int kind;  // 0 = shift (val = fsm_notes), 1 = row transfer (val = y_level)
    int val;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start_a = 1'b0, pause_a = 1'b0, ack_a = 1'b1;
  logic [2:0] addr_a, y_a;
  logic [4:0] note_a, notes_a;
  logic       shift_a, valid_a, playing_a, done_a, ovr_a;

  logic       start_b = 1'b0, pause_b = 1'b0, ack_b = 1'b1;
  logic [2:0] addr_b, y_b;
  logic [4:0] note_b, notes_b;
  logic       shift_b, valid_b, playing_b, done_b, ovr_b;

  logic [4:0] rom [4] = '{5'h01, 5'h02, 5'h04, 5'h10};

  int   cyc = 0;
  int   base_a = 0, base_b = 0;
  int   errors = 0, checks = 0;
  int   max_addr_a = 0;
  ev_t  exp_a[$], obs_a[$], exp_b[$], obs_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    note_a <= (addr_a < 3'd4) ? rom[addr_a[1:0]] : 5'h1f;
    note_b <= (addr_b < 3'd4) ? rom[addr_b[1:0]] : 5'h1f;
  end

  note_scroll_controller #(.TICKS_PER_ROW(4), .SONG_LEN(4), .ADDR_W(3), .ROWS(8)) dut_a (
    .clk(clk), .reset(rst), .start(start_a), .pause(pause_a), .song_addr(addr_a),
    .song_note(note_a), .shift_enable(shift_a), .fsm_notes(notes_a), .y_level(y_a),
    .row_valid(valid_a), .row_ack(ack_a), .playing(playing_a), .done(done_a), .overrun(ovr_a)
  );

  note_scroll_controller #(.TICKS_PER_ROW(16), .SONG_LEN(4), .ADDR_W(3), .ROWS(8)) dut_b (
    .clk(clk), .reset(rst), .start(start_b), .pause(pause_b), .song_addr(addr_b),
    .song_note(note_b), .shift_enable(shift_b), .fsm_notes(notes_b), .y_level(y_b),
    .row_valid(valid_b), .row_ack(ack_b), .playing(playing_b), .done(done_b), .overrun(ovr_b)
  );

  // Observer: records DUT output events mid-cycle
  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      if (shift_a) begin e.cyc = cyc; e.kind = 0; e.val = int'(notes_a); obs_a.push_back(e); end
      if (valid_a && ack_a) begin e.cyc = cyc; e.kind = 1; e.val = int'(y_a); obs_a.push_back(e); end
      if (shift_b) begin e.cyc = cyc; e.kind = 0; e.val = int'(notes_b); obs_b.push_back(e); end
      if (valid_b && ack_b) begin e.cyc = cyc; e.kind = 1; e.val = int'(y_b); obs_b.push_back(e); end
      if (int'(addr_a) > max_addr_a) max_addr_a = int'(addr_a);
    end
  end

  task automatic push_exp_a(input int c, input int kind, input int val);
    ev_t e;
    e.cyc = base_a + c; e.kind = kind; e.val = val;
    exp_a.push_back(e);
  endtask

  task automatic push_exp_b(input int c, input int kind, input int val);
    ev_t e;
    e.cyc = base_b + c; e.kind = kind; e.val = val;
    exp_b.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({shift_a, notes_a, y_a, valid_a, playing_a, done_a, ovr_a, addr_a} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_a: got %b, expected all zero",
               {shift_a, notes_a, y_a, valid_a, playing_a, done_a, ovr_a, addr_a});
    end
    checks++;
    if ({shift_b, notes_b, y_b, valid_b, playing_b, done_b, ovr_b, addr_b} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_b: got %b, expected all zero",
               {shift_b, notes_b, y_b, valid_b, playing_b, done_b, ovr_b, addr_b});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Full song on dut_a; every period is SHIFT + 8 DRAW + FETCH + WAIT = 11 cycles
  task automatic test_full_run(input string tag);
    ev_t e, o;
    int  nshift;
    @(posedge clk); #1;
    start_a = 1'b1;
    ack_a   = 1'b1;
    base_a  = cyc;
    for (int j = 0; j < 12; j++) begin
      push_exp_a(5 + 11 * j, 0, (j < 4) ? int'(rom[j]) : 0);
      for (int r = 0; r < 8; r++) push_exp_a(6 + 11 * j + r, 1, r);
    end
    @(posedge clk); #1;
    start_a = 1'b0;
    checks++;
    if (addr_a !== 3'd0 || ovr_a !== 1'b0 || playing_a !== 1'b1) begin
      errors++;
      $display("FAIL %s_start_state: addr=%0d ovr=%b playing=%b, expected 0 0 1", tag, addr_a, ovr_a, playing_a);
    end
    while (done_a !== 1'b1 && (cyc - base_a) < 160) begin
      @(posedge clk); #1;
    end
    checks++;
    if ((cyc - base_a) !== 135 || done_a !== 1'b1 || playing_a !== 1'b0 || ovr_a !== 1'b1) begin
      errors++;
      $display("FAIL %s_done: cycle=%0d done=%b playing=%b ovr=%b, expected 135 1 0 1",
               tag, cyc - base_a, done_a, playing_a, ovr_a);
    end
    checks++;
    if (max_addr_a > 3) begin
      errors++;
      $display("FAIL %s_addr_range: max song_addr=%0d, expected <= 3", tag, max_addr_a);
    end
    nshift = 0;
    while (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      checks++;
      if (obs_a.size() == 0) begin
        errors++;
        $display("FAIL %s_event: got none, expected cyc=%0d kind=%0d val=%0h", tag, e.cyc - base_a, e.kind, e.val);
      end else begin
        o = obs_a.pop_front();
        if (o.kind == 0) nshift++;
        if (o.cyc !== e.cyc || o.kind !== e.kind || o.val !== e.val) begin
          errors++;
          $display("FAIL %s_event: got cyc=%0d kind=%0d val=%0h, expected cyc=%0d kind=%0d val=%0h",
                   tag, o.cyc - base_a, o.kind, o.val, e.cyc - base_a, e.kind, e.val);
        end
      end
    end
    checks++;
    if (nshift !== 12 || obs_a.size() !== 0) begin
      errors++;
      $display("FAIL %s_shift_count: got %0d shifts and %0d extra events, expected 12 and 0", tag, nshift, obs_a.size());
    end
  endtask

  // dut_b: drawer stalls 40 cycles in the first DRAW, so two ticks land there
  task automatic test_overrun();
    ev_t e, o;
    @(posedge clk); #1;
    start_b = 1'b1;
    ack_b   = 1'b1;
    base_b  = cyc;
    push_exp_b(17, 0, 5'h01);
    for (int r = 0; r < 8; r++) push_exp_b(58 + r, 1, r);
    push_exp_b(68, 0, 5'h02);
    for (int r = 0; r < 8; r++) push_exp_b(69 + r, 1, r);
    for (int k = 1; k <= 77; k++) begin
      @(posedge clk); #1;
      if (k == 1) start_b = 1'b0;
      if (k == 17) ack_b = 1'b0;
      if (k == 58) ack_b = 1'b1;
      if (k == 40) begin
        checks++;
        if (valid_b !== 1'b1 || y_b !== 3'd0) begin
          errors++;
          $display("FAIL stall_row: valid=%b y=%0d, expected 1 0", valid_b, y_b);
        end
      end
      if (k == 45) begin
        checks++;
        if (ovr_b !== 1'b0) begin
          errors++;
          $display("FAIL overrun_early: got %b, expected 0", ovr_b);
        end
      end
      if (k == 50) begin
        checks++;
        if (ovr_b !== 1'b1) begin
          errors++;
          $display("FAIL overrun_set: got %b, expected 1", ovr_b);
        end
      end
    end
    while (exp_b.size() > 0) begin
      e = exp_b.pop_front();
      checks++;
      if (obs_b.size() == 0) begin
        errors++;
        $display("FAIL overrun_event: got none, expected cyc=%0d kind=%0d val=%0h", e.cyc - base_b, e.kind, e.val);
      end else begin
        o = obs_b.pop_front();
        if (o.cyc !== e.cyc || o.kind !== e.kind || o.val !== e.val) begin
          errors++;
          $display("FAIL overrun_event: got cyc=%0d kind=%0d val=%0h, expected cyc=%0d kind=%0d val=%0h",
                   o.cyc - base_b, o.kind, o.val, e.cyc - base_b, e.kind, e.val);
        end
      end
    end
  endtask

  // Continues dut_b: WAIT_TICK entered at 78, unpaused shift would be 81
  task automatic test_pause();
    ev_t e, o;
    push_exp_b(101, 0, 5'h04);
    for (int k = 78; k <= 102; k++) begin
      @(posedge clk); #1;
      if (k == 78) pause_b = 1'b1;
      if (k == 98) pause_b = 1'b0;
      if (k == 90) begin
        checks++;
        if (playing_b !== 1'b1 || valid_b !== 1'b0 || ovr_b !== 1'b1) begin
          errors++;
          $display("FAIL pause_hold: playing=%b valid=%b ovr=%b, expected 1 0 1", playing_b, valid_b, ovr_b);
        end
      end
    end
    while (exp_b.size() > 0) begin
      e = exp_b.pop_front();
      checks++;
      if (obs_b.size() == 0) begin
        errors++;
        $display("FAIL pause_event: got none, expected cyc=%0d kind=%0d val=%0h", e.cyc - base_b, e.kind, e.val);
      end else begin
        o = obs_b.pop_front();
        if (o.cyc !== e.cyc || o.kind !== e.kind || o.val !== e.val) begin
          errors++;
          $display("FAIL pause_event: got cyc=%0d kind=%0d val=%0h, expected cyc=%0d kind=%0d val=%0h",
                   o.cyc - base_b, o.kind, o.val, e.cyc - base_b, e.kind, e.val);
        end
      end
    end
  endtask

  // Continues dut_b: stray start in DRAW, async reset at y_level=5, then a clean restart
  task automatic test_async_reset();
    ev_t e, o;
    for (int r = 0; r < 6; r++) push_exp_b(102 + r, 1, r);
    for (int k = 103; k <= 107; k++) begin
      @(posedge clk); #1;
      if (k == 104) start_b = 1'b1;
      if (k == 105) start_b = 1'b0;
    end
    checks++;
    if (valid_b !== 1'b1 || y_b !== 3'd5) begin
      errors++;
      $display("FAIL pre_reset_row: valid=%b y=%0d, expected 1 5", valid_b, y_b);
    end
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({shift_b, notes_b, y_b, valid_b, playing_b, done_b, ovr_b, addr_b} !== '0) begin
      errors++;
      $display("FAIL async_reset_b: got %b, expected all zero",
               {shift_b, notes_b, y_b, valid_b, playing_b, done_b, ovr_b, addr_b});
    end
    checks++;
    if ({done_a, ovr_a, addr_a} !== '0) begin
      errors++;
      $display("FAIL async_reset_a: done=%b ovr=%b addr=%0d, expected 0 0 0", done_a, ovr_a, addr_a);
    end
    @(negedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    start_b = 1'b1;
    base_b  = cyc;
    push_exp_b(17, 0, 5'h01);
    for (int r = 0; r < 8; r++) push_exp_b(18 + r, 1, r);
    for (int k = 1; k <= 26; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        start_b = 1'b0;
        checks++;
        if (addr_b !== 3'd0 || ovr_b !== 1'b0 || playing_b !== 1'b1) begin
          errors++;
          $display("FAIL restart_state: addr=%0d ovr=%b playing=%b, expected 0 0 1", addr_b, ovr_b, playing_b);
        end
      end
    end
    while (exp_b.size() > 0) begin
      e = exp_b.pop_front();
      checks++;
      if (obs_b.size() == 0) begin
        errors++;
        $display("FAIL reset_event: got none, expected cyc=%0d kind=%0d val=%0h", e.cyc - base_b, e.kind, e.val);
      end else begin
        o = obs_b.pop_front();
        if (o.cyc !== e.cyc || o.kind !== e.kind || o.val !== e.val) begin
          errors++;
          $display("FAIL reset_event: got cyc=%0d kind=%0d val=%0h, expected cyc=%0d kind=%0d val=%0h",
                   o.cyc - base_b, o.kind, o.val, e.cyc - base_b, e.kind, e.val);
        end
      end
    end
    checks++;
    if (obs_b.size() !== 0) begin
      errors++;
      $display("FAIL extra_events_b: got %0d unexpected events, expected 0", obs_b.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_full_run("run1");
    test_full_run("restart_from_done");
    test_overrun();
    test_pause();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
